// File: rtl/dct_sched_pkg.sv
// dct_sched_pkg: shared stage-state encoding and sizing helpers for the DCT block scheduler
package dct_sched_pkg;
  typedef enum logic [1:0] {EMPTY, RUN, FULL} stage_t;
  localparam stage_t LOAD = RUN;
  localparam int ROWS_DEF = 8;
  function automatic int row_w(input int rows);
    return rows > 1 ? $clog2(rows) : 1;
  endfunction
endpackage

// File: rtl/dct_stage_slot.sv
// dct_stage_slot: one pipeline stage, a state register plus a row counter
module dct_stage_slot import dct_sched_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter stage_t INIT = EMPTY,
  localparam int W = row_w(ROWS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         adv,
  input  logic         clear,
  output logic [1:0]   state,
  output logic [W-1:0] cnt,
  output logic         last
);
  assign last = cnt == W'(ROWS - 1);
  // a refill on the same edge as a release wins, which gives bubble-free handoff
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= start ? RUN : clear ? EMPTY : (adv && last) ? FULL : state;
      cnt   <= start ? '0 : adv ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/dct_pipe_sched.sv
// dct_pipe_sched: LOAD/XFER/DRAIN sequencing, bank ping-pong and block counting for the 2-D DCT
module dct_pipe_sched import dct_sched_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int BLK_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    tp1_wr_en,
  output logic                    tp1_wr_bank,
  output logic                    tp1_rd_en,
  output logic                    dct2_dc,
  output logic                    tp2_wr_en,
  output logic                    tp2_wr_bank,
  output logic                    tp2_rd_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [row_w(ROWS)-1:0]  out_row,
  output logic                    blk_done,
  output logic [BLK_W-1:0]        blk_cnt,
  output logic                    busy
);
  localparam int W = row_w(ROWS);
  logic [1:0] a_st, b_st, c_st;
  logic [W-1:0] a_cnt, b_cnt;
  logic a_last, b_last, c_last, ho_ab, ho_bc;
  assign in_ready  = a_st == LOAD;
  assign tp1_wr_en = in_valid && in_ready;
  assign tp1_rd_en = b_st == RUN;
  assign tp2_wr_en = tp1_rd_en;
  assign dct2_dc   = tp1_rd_en && b_cnt == '0;
  assign out_valid = c_st == RUN;
  assign tp2_rd_en = out_valid && out_ready;
  assign blk_done  = tp2_rd_en && c_last;
  assign ho_bc     = b_st == FULL && (c_st == EMPTY || blk_done);
  assign ho_ab     = a_st == FULL && (b_st == EMPTY || ho_bc);
  assign busy      = a_st == FULL || a_cnt != '0 || b_st != EMPTY || c_st != EMPTY;
  dct_stage_slot #(.ROWS(ROWS), .INIT(LOAD)) u_a (
    .clk, .reset, .start(ho_ab), .adv(tp1_wr_en), .clear(1'b0),
    .state(a_st), .cnt(a_cnt), .last(a_last)
  );
  dct_stage_slot #(.ROWS(ROWS), .INIT(EMPTY)) u_b (
    .clk, .reset, .start(ho_ab), .adv(tp1_rd_en), .clear(ho_bc),
    .state(b_st), .cnt(b_cnt), .last(b_last)
  );
  dct_stage_slot #(.ROWS(ROWS), .INIT(EMPTY)) u_c (
    .clk, .reset, .start(ho_bc), .adv(tp2_rd_en), .clear(blk_done),
    .state(c_st), .cnt(out_row), .last(c_last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      tp1_wr_bank <= 1'b0;
      tp2_wr_bank <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      tp1_wr_bank <= tp1_wr_bank ^ ho_ab;
      tp2_wr_bank <= tp2_wr_bank ^ ho_bc;
      blk_cnt     <= blk_cnt + BLK_W'(blk_done);
    end
  end
  // row counters only reach their last row while the stage is filling
  a_last_in_load: assert property (@(posedge clk) disable iff (reset) a_last |-> a_st == LOAD);
  b_last_in_run: assert property (@(posedge clk) disable iff (reset) b_last |-> b_st == RUN);
endmodule

// File: tb/tb_dct_pipe_sched.sv
// tb_dct_pipe_sched: directed cycle-by-cycle checks of the DCT block scheduler
module tb_dct_pipe_sched;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, tp1_wr_en, tp1_wr_bank, tp1_rd_en, dct2_dc, tp2_wr_en, tp2_wr_bank;
  logic tp2_rd_en, out_valid, blk_done, busy;
  logic [2:0] out_row;
  logic [3:0] blk_cnt;
  int errs = 0, checks = 0;

  dct_pipe_sched #(.ROWS(8), .BLK_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .tp1_wr_en(tp1_wr_en), .tp1_wr_bank(tp1_wr_bank), .tp1_rd_en(tp1_rd_en),
    .dct2_dc(dct2_dc), .tp2_wr_en(tp2_wr_en), .tp2_wr_bank(tp2_wr_bank),
    .tp2_rd_en(tp2_rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .blk_done(blk_done), .blk_cnt(blk_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] ctl();
    return {in_ready, tp1_wr_en, tp1_rd_en, dct2_dc, tp2_wr_en, out_valid, tp2_rd_en, blk_done};
  endfunction

  initial begin
    int sent, got, exp_row, low, n_ov, n_done;
    logic xf, ov, ir;
    rst();
    #2;
    chk("reset state", {ctl(), tp1_wr_bank, tp2_wr_bank, busy, out_row, blk_cnt}, {8'b1000_0000, 10'd0});
    tick();

    rst();
    for (int t = 0; t < 28; t++) begin
      in_valid = t < 8;
      #2;
      xf = t >= 9 && t <= 16;
      ov = t >= 18 && t <= 25;
      chk($sformatf("single ctl t=%0d", t), ctl(), {t != 8, t < 8, xf, t == 9, xf, ov, ov, t == 25});
      chk($sformatf("single bank t=%0d", t), {tp1_wr_bank, tp2_wr_bank, busy}, {t >= 9, t >= 18, t >= 1 && t <= 25});
      if (ov) chk($sformatf("single row t=%0d", t), out_row, t - 18);
      tick();
    end
    chk("single blk_cnt", blk_cnt, 1);

    rst();
    for (int t = 0; t < 55; t++) begin
      in_valid = t < 35;
      #2;
      ir = !(t % 9 == 8 && t <= 35);
      xf = t >= 9 && t <= 43 && (t - 9) % 9 < 8;
      ov = t >= 18 && t <= 52 && (t - 18) % 9 < 8;
      chk($sformatf("stream ctl t=%0d", t), ctl(),
          {ir, t < 35 && ir, xf, xf && (t - 9) % 9 == 0, xf, ov, ov, ov && (t - 18) % 9 == 7});
      if (t <= 35) chk($sformatf("stream bank t=%0d", t), tp1_wr_bank, (t / 9) % 2);
      if (ov) chk($sformatf("stream row t=%0d", t), out_row, (t - 18) % 9);
      tick();
    end
    chk("stream blk_cnt", blk_cnt, 4);

    rst();
    sent = 0; got = 0; exp_row = 0; low = 0;
    for (int t = 0; t < 100; t++) begin
      in_valid = sent < 24;
      out_ready = !(t >= 20 && t < 50);
      #2;
      if (t >= 26 && t < 50 && !in_ready) low++;
      if (t == 49) chk("stall state", {in_ready, out_valid, out_row, tp1_rd_en, tp1_wr_en, busy},
                       {1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1});
      if (t == 56) chk("no bubble", {out_valid, out_row}, {1'b1, 3'd0});
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("bp row t=%0d", t), out_row, exp_row);
        exp_row = (exp_row + 1) % 8;
        got++;
      end
      tick();
    end
    out_ready = 1'b1;
    chk("bp rows in", sent, 24);
    chk("bp rows out", got, 24);
    chk("bp in_ready low", low, 24);
    chk("bp blk_cnt", blk_cnt, 3);

    for (int t = 0; t < 13; t++) begin
      in_valid = 1'b1;
      reset = t == 12;
      #2;
      tick();
    end
    reset = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("post reset", {in_ready, out_valid, tp1_wr_bank, tp2_wr_bank, blk_cnt, busy},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
    n_ov = 0;
    for (int t = 0; t < 30; t++) begin
      #2;
      if (out_valid || busy) n_ov++;
      tick();
    end
    chk("post reset idle", n_ov, 0);

    rst();
    for (int t = 0; t < 35; t++) begin
      in_valid = t % 2 == 0 && t < 16;
      #2;
      xf = t >= 16 && t <= 23;
      ov = t >= 25 && t <= 32;
      chk($sformatf("toggle ctl t=%0d", t), ctl(),
          {t != 15, t % 2 == 0 && t < 15, xf, t == 16, xf, ov, ov, t == 32});
      if (ov) chk($sformatf("toggle row t=%0d", t), out_row, t - 25);
      tick();
    end
    chk("toggle blk_cnt", blk_cnt, 1);

    rst();
    sent = 0; n_done = 0;
    for (int t = 0; t < 186; t++) begin
      in_valid = sent < 136;
      #2;
      if (in_valid && in_ready) sent++;
      if (blk_done) n_done++;
      if (t == 161) chk("wrap at 16", blk_cnt, 0);
      tick();
    end
    chk("wrap done count", n_done, 17);
    chk("wrap blk_cnt", blk_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
